// File: rtl/dcache_refill_buffer_pkg.sv
// Shared types and AXI constants for the data-cache refill engine.
package refill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        WRITE = 2'd3
    } refill_state_e;

    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [7:0] REFILL_LEN     = 8'd7;
    localparam int         LINE_WORDS     = 8;

    // WRAP bursts return the critical word first, so beat n lands n slots past it.
    function automatic logic [2:0] slot_of(input logic [2:0] idx, input logic [2:0] cnt);
        return idx + cnt;
    endfunction

endpackage

// File: rtl/dcache_refill_buffer_if.sv
// Pipeline request, AXI read channel and bank refill port of the refill engine.
interface dcache_refill_buffer_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                                       req_valid;
    logic                                       req_ready;
    logic [31:0]                                req_addr;

    logic                                       ar_valid;
    logic                                       ar_ready;
    logic [31:0]                                ar_addr;
    logic [7:0]                                 ar_len;
    logic [2:0]                                 ar_size;
    logic [1:0]                                 ar_burst;

    logic                                       r_valid;
    logic                                       r_ready;
    logic [DATA_WIDTH-1:0]                      r_data;
    logic [1:0]                                 r_resp;
    logic                                       r_last;

    logic                                       crit_valid;
    logic [DATA_WIDTH-1:0]                      crit_data;

    logic                                       hit_write;
    logic                                       we;
    logic [ADDR_WIDTH-1:0]                      waddr;
    logic [DATA_WIDTH*refill_pkg::LINE_WORDS-1:0] din_all;
    logic                                       done;
    logic                                       err;

    modport master (
        input  req_valid, req_addr, ar_ready, r_valid, r_data, r_resp, r_last,
        output req_ready, ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready,
               crit_valid, crit_data, hit_write, we, waddr, din_all, done, err
    );

    modport slave (
        output req_valid, req_addr, ar_ready, r_valid, r_data, r_resp, r_last,
        input  req_ready, ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready,
               crit_valid, crit_data, hit_write, we, waddr, din_all, done, err
    );

endinterface

// File: rtl/dcache_refill_buffer.sv
// Data-cache refill engine: one 8-beat AXI WRAP read per miss, critical word
// forwarded early, assembled line written to the bank in a single cycle.
module dcache_refill_buffer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    dcache_refill_buffer_if.master bus
);
    import refill_pkg::*;

    refill_state_e                    r_state;
    logic [31:0]                      r_req_addr;
    logic [2:0]                       r_cnt;
    logic                             r_bad;
    logic                             r_crit_valid;
    logic [DATA_WIDTH-1:0]            r_crit_data;
    logic [DATA_WIDTH*LINE_WORDS-1:0] r_line;

    logic       w_beat;
    logic [2:0] w_slot;
    logic       w_last_beat;
    logic       w_len_err;
    logic       w_write;

    assign w_beat      = (r_state == DATA) && bus.r_valid;
    assign w_slot      = slot_of(r_req_addr[4:2], r_cnt);
    assign w_last_beat = bus.r_last || (r_cnt == 3'd7);
    // Burst length violation either way: early r_last, or no r_last on beat 8.
    assign w_len_err   = bus.r_last != (r_cnt == 3'd7);
    assign w_write     = (r_state == WRITE) && !r_bad;

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.ar_valid   = (r_state == ADDR);
    assign bus.ar_addr    = r_req_addr & ~32'h3;
    assign bus.ar_len     = REFILL_LEN;
    assign bus.ar_size    = AXI_SIZE_WORD;
    assign bus.ar_burst   = AXI_BURST_WRAP;
    assign bus.r_ready    = (r_state == DATA);
    assign bus.crit_valid = r_crit_valid;
    assign bus.crit_data  = r_crit_data;
    assign bus.hit_write  = w_write;
    assign bus.we         = w_write;
    assign bus.waddr      = {r_req_addr[ADDR_WIDTH+1:5], 3'b000};
    assign bus.din_all    = r_line;
    assign bus.done       = (r_state == WRITE);
    assign bus.err        = (r_state == WRITE) && r_bad;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_req_addr   <= '0;
            r_cnt        <= '0;
            r_bad        <= 1'b0;
            r_crit_valid <= 1'b0;
            r_crit_data  <= '0;
            // NOTE: the line store is ordinary flops feeding din_all, so it is reset like any other register.
            r_line       <= '0;
        end else begin
            r_crit_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_req_addr <= bus.req_addr;
                        r_cnt      <= '0;
                        r_bad      <= 1'b0;
                        r_state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.ar_ready) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_beat) begin
                        for (int k = 0; k < LINE_WORDS; k++) begin
                            if (w_slot == 3'(k)) begin
                                r_line[k*DATA_WIDTH +: DATA_WIDTH] <= bus.r_data;
                            end
                        end
                        if (r_cnt == 3'd0) begin
                            r_crit_data  <= bus.r_data;
                            r_crit_valid <= 1'b1;
                        end
                        if ((bus.r_resp != 2'b00) || w_len_err) begin
                            r_bad <= 1'b1;
                        end
                        r_cnt <= r_cnt + 3'd1;
                        if (w_last_beat) begin
                            r_state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_refill_buffer.sv
// Self-checking bench for dcache_refill_buffer: a transaction timeline model
// predicts every output each cycle, plus literal expectations per scenario.
module tb_dcache_refill_buffer;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    dcache_refill_buffer_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

    dcache_refill_buffer #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(32),
        .LINE_WORDS(8)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    initial forever #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Model: the planned timeline of the current refill and its expected results.
    bit           m_active = 1'b0;
    int           t_req, t_ar, t_first, t_last;
    bit           m_bad;
    logic [31:0]  m_ar_addr, m_crit;
    logic [9:0]   m_waddr;
    logic [255:0] m_line = '0;

    // What the DUT actually did during the current refill.
    int           cap_done_cyc;
    int           hits;
    logic [31:0]  cap_ar_addr, cap_crit;
    logic [9:0]   cap_waddr;
    logic [255:0] cap_line;
    logic         cap_err;

    logic e_busy, e_ar, e_r, e_crit, e_done;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            check("rst req_ready", bus.req_ready, 1'b1);
            check("rst ar_valid", bus.ar_valid, 1'b0);
            check("rst r_ready", bus.r_ready, 1'b0);
            check("rst crit_valid", bus.crit_valid, 1'b0);
            check("rst hit_write", bus.hit_write, 1'b0);
            check("rst we", bus.we, 1'b0);
            check("rst done", bus.done, 1'b0);
            check("rst err", bus.err, 1'b0);
            check("rst crit_data", bus.crit_data, 32'h0);
            check("rst din_all", bus.din_all, 256'h0);
            check("rst waddr", bus.waddr, 10'h0);
        end else begin
            e_busy = m_active && cyc >= t_req + 1 && cyc <= t_last + 1;
            e_ar   = m_active && cyc >= t_req + 1 && cyc <= t_ar;
            e_r    = m_active && cyc > t_ar && cyc <= t_last;
            e_crit = m_active && cyc == t_first + 1;
            e_done = m_active && cyc == t_last + 1;
            check("req_ready", bus.req_ready, !e_busy);
            check("ar_valid", bus.ar_valid, e_ar);
            check("r_ready", bus.r_ready, e_r);
            check("crit_valid", bus.crit_valid, e_crit);
            check("done", bus.done, e_done);
            check("hit_write", bus.hit_write, e_done && !m_bad);
            check("we", bus.we, e_done && !m_bad);
            check("err", bus.err, e_done && m_bad);
            if (e_ar) begin
                check("ar_addr", bus.ar_addr, m_ar_addr);
                check("ar_len", bus.ar_len, 8'd7);
                check("ar_size", bus.ar_size, 3'b010);
                check("ar_burst", bus.ar_burst, 2'b10);
            end
            if (e_crit) check("crit_data", bus.crit_data, m_crit);
            if (e_done) begin
                check("din_all", bus.din_all, m_line);
                check("waddr", bus.waddr, m_waddr);
            end
        end
        if (bus.ar_valid)   cap_ar_addr = bus.ar_addr;
        if (bus.crit_valid) cap_crit = bus.crit_data;
        if (bus.hit_write)  hits++;
        if (bus.done) begin
            cap_done_cyc = cyc;
            cap_line     = bus.din_all;
            cap_waddr    = bus.waddr;
            cap_err      = bus.err;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.ar_ready  = 1'b0;
        bus.r_valid   = 1'b0;
        bus.r_data    = 32'h0;
        bus.r_resp    = 2'b00;
        bus.r_last    = 1'b0;
    endtask

    // last_at: beat carrying r_last (8 = never); bad_beat: beat with SLVERR; abort_at: beat hit by reset.
    task automatic run_txn(input logic [31:0] addr, input int ar_delay, input bit gaps,
                           input int last_at, input int bad_beat, input logic [31:0] base,
                           input int abort_at);
        int n, step, idx;
        n    = (last_at < 7) ? last_at + 1 : 8;
        step = gaps ? 2 : 1;
        idx  = int'((addr >> 2) & 32'h7);
        t_req   = cyc;
        t_ar    = t_req + 1 + ar_delay;
        t_first = t_ar + 1;
        t_last  = t_first + (n - 1) * step;
        m_bad     = (bad_beat >= 0 && bad_beat < n) || (last_at != 7);
        m_ar_addr = addr & ~32'h3;
        m_crit    = base;
        m_waddr   = 10'(((addr / 32) % 128) * 8);
        for (int i = 0; i < n; i++) m_line[((idx + i) % 8) * 32 +: 32] = base + 32'(i);
        hits = 0;
        cap_done_cyc = -1;
        cap_err  = 1'bx;
        cap_line = 'x;
        cap_crit = 'x;
        m_active = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        for (int c = t_req + 1; c <= t_last + 1; c++) begin
            tick();
            idle_inputs();
            if (c <= t_ar) begin
                bus.req_valid = 1'b1;
                bus.req_addr  = 32'hDEAD_BEEC;
            end
            bus.ar_ready = (c == t_ar);
            if (c >= t_first && c <= t_last && (c - t_first) % step == 0) begin
                int bi;
                bi = (c - t_first) / step;
                if (bi == abort_at) begin
                    i_rst_n  = 1'b0;
                    m_active = 1'b0;
                    m_line   = '0;
                    repeat (2) tick();
                    i_rst_n = 1'b1;
                    return;
                end
                bus.r_valid = 1'b1;
                bus.r_data  = base + 32'(bi);
                bus.r_resp  = (bi == bad_beat) ? 2'b10 : 2'b00;
                bus.r_last  = (bi == last_at);
            end
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        i_rst_n = 1'b0;
        repeat (3) tick();
        i_rst_n = 1'b1;
        tick();

        run_txn(32'h0000_1A00, 0, 1'b0, 7, -1, 32'h100, -1);
        check("aligned ar_addr", cap_ar_addr, 32'h0000_1A00);
        check("aligned waddr", cap_waddr, 10'h280);
        check("aligned crit", cap_crit, 32'h100);
        check("aligned line", cap_line,
              256'h00000107_00000106_00000105_00000104_00000103_00000102_00000101_00000100);
        check("aligned err", cap_err, 1'b0);
        check("aligned hits", hits, 1);
        check("aligned latency", cap_done_cyc - t_req, 10);

        run_txn(32'h0000_1A14, 0, 1'b0, 7, -1, 32'hD0, -1);
        check("wrap ar_addr", cap_ar_addr, 32'h0000_1A14);
        check("wrap crit", cap_crit, 32'hD0);
        check("wrap word5", cap_line[5*32 +: 32], 32'hD0);
        check("wrap word7", cap_line[7*32 +: 32], 32'hD2);
        check("wrap word0", cap_line[0*32 +: 32], 32'hD3);
        check("wrap word4", cap_line[4*32 +: 32], 32'hD7);

        run_txn(32'h0000_1A00, 3, 1'b1, 7, -1, 32'h100, -1);
        check("stall line", cap_line,
              256'h00000107_00000106_00000105_00000104_00000103_00000102_00000101_00000100);
        check("stall latency", cap_done_cyc - t_req, 20);
        check("stall hits", hits, 1);

        run_txn(32'h0000_0040, 0, 1'b0, 7, 3, 32'h200, -1);
        check("slverr err", cap_err, 1'b1);
        check("slverr hits", hits, 0);
        check("slverr latency", cap_done_cyc - t_req, 10);

        run_txn(32'h0000_0080, 0, 1'b0, 4, -1, 32'h300, -1);
        check("early last err", cap_err, 1'b1);
        check("early last hits", hits, 0);
        check("early last latency", cap_done_cyc - t_req, 7);

        run_txn(32'h0000_00C4, 0, 1'b0, 7, -1, 32'h400, -1);
        check("after early err", cap_err, 1'b0);
        check("after early hits", hits, 1);
        check("after early word1", cap_line[1*32 +: 32], 32'h400);

        run_txn(32'h0000_001C, 0, 1'b0, 0, -1, 32'h800, -1);
        check("one beat crit", cap_crit, 32'h800);
        check("one beat err", cap_err, 1'b1);
        check("one beat latency", cap_done_cyc - t_req, 3);

        run_txn(32'h0000_0020, 0, 1'b0, 8, -1, 32'h700, -1);
        check("no last err", cap_err, 1'b1);
        check("no last latency", cap_done_cyc - t_req, 10);

        run_txn(32'h0000_1A00, 0, 1'b0, 7, -1, 32'h500, 5);
        check("abort hits", hits, 0);
        check("abort no done", cap_done_cyc, -1);

        run_txn(32'h0000_3FE0, 0, 1'b0, 7, -1, 32'h600, -1);
        check("fresh waddr", cap_waddr, 10'h3F8);
        check("fresh line", cap_line,
              256'h00000607_00000606_00000605_00000604_00000603_00000602_00000601_00000600);
        check("fresh err", cap_err, 1'b0);
        check("fresh hits", hits, 1);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
